hazard_control_unit: RTL

- Pipeline hazard and stall controller for the 5-stage MIPS/DLX core. It sits in ID, alongside the EX-stage forwarding unit.
- Decides when forwarding cannot resolve a dependency. Generates PC/IF-ID write-enables, ID/EX bubbles and branch flushes.
- Sequences the multicycle mult/div unit (MDU) handshake, stalling the front end until the MDU returns.

---
 rtl/hazard_control_unit_pkg.sv | 15 +
 rtl/hazard_control_unit_if.sv | 50 +++++
 rtl/hazard_timeout_counter.sv | 40 ++++
 rtl/hazard_control_unit.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/hazard_control_unit_pkg.sv
// rtl/hazard_control_unit_pkg.sv - shared pipeline constants and hazard FSM encoding
// Package cpu_pkg: register-address width and zero-register constant (shared
// with the forwarding unit) plus the hazard controller state encoding.
package cpu_pkg;

    localparam int REG_ADDR_W = 5;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;

    typedef enum logic [1:0] {
        ST_RUN        = 2'b00,
        ST_LOAD_STALL = 2'b01,
        ST_MDU_WAIT   = 2'b10
    } hcu_state_e;

endpackage

// File: rtl/hazard_control_unit_if.sv
// rtl/hazard_control_unit_if.sv - ID-stage hazard controller signal bundle
// Interface hazard_control_unit_if.
//   master: pipeline side, drives register/decode/EX status and mdu_done,
//           receives the stall/flush/MDU controls.
//   slave : hazard controller side.
// Optional macro HAZARD_STATS_EN adds stall_cycles / flush_count.
interface hazard_control_unit_if #(
    parameter int REG_ADDR_W = cpu_pkg::REG_ADDR_W
`ifdef HAZARD_STATS_EN
    , parameter int CNT_W = 16
`endif
);
    logic [REG_ADDR_W-1:0] rs_ID;
    logic [REG_ADDR_W-1:0] rt_ID;
    logic                  uses_rt_ID;
    logic                  mdu_op_ID;
    logic [REG_ADDR_W-1:0] rw_ID_EX;
    logic                  mem_read_EX;
    logic                  branch_taken_EX;
    logic                  mdu_done;
    logic                  pc_write;
    logic                  if_id_write;
    logic                  id_ex_bubble;
    logic                  if_id_flush;
    logic                  mdu_start;
    logic                  mdu_error;
`ifdef HAZARD_STATS_EN
    logic [CNT_W-1:0]      stall_cycles;
    logic [CNT_W-1:0]      flush_count;
`endif

    modport master (
        output rs_ID, rt_ID, uses_rt_ID, mdu_op_ID, rw_ID_EX, mem_read_EX,
               branch_taken_EX, mdu_done,
        input  pc_write, if_id_write, id_ex_bubble, if_id_flush, mdu_start, mdu_error
`ifdef HAZARD_STATS_EN
        , input stall_cycles, flush_count
`endif
    );

    modport slave (
        input  rs_ID, rt_ID, uses_rt_ID, mdu_op_ID, rw_ID_EX, mem_read_EX,
               branch_taken_EX, mdu_done,
        output pc_write, if_id_write, id_ex_bubble, if_id_flush, mdu_start, mdu_error
`ifdef HAZARD_STATS_EN
        , output stall_cycles, flush_count
`endif
    );

endinterface

// File: rtl/hazard_timeout_counter.sv
// rtl/hazard_timeout_counter.sv - saturating counter with clear, enable and terminal flag
// Ports: clk, reset (async, active-high), clr_i (synchronous clear, wins over
// en_i), en_i (count up), cnt_o (current value), tc_o (value == TC_VALUE).
// The counter stops at TC_VALUE, so it never wraps.
module hazard_timeout_counter #(
    parameter int             W        = 8,
    parameter logic [W-1:0]   TC_VALUE = '1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr_i,
    input  logic         en_i,
    output logic [W-1:0] cnt_o,
    output logic         tc_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign tc_o  = (cnt_q == TC_VALUE);
    assign cnt_o = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && !tc_o) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/hazard_control_unit.sv
// rtl/hazard_control_unit.sv - load-use / branch / MDU hazard and stall controller
// Ports: clk, reset (async, active-high); bus (hazard_control_unit_if.slave)
// carrying ID/EX status in and pc_write, if_id_write, id_ex_bubble,
// if_id_flush, mdu_start, mdu_error out.
// Optional macro HAZARD_STATS_EN adds the stall_cycles / flush_count counters.
module hazard_control_unit
    import cpu_pkg::*;
#(
    parameter int REG_ADDR_W  = cpu_pkg::REG_ADDR_W,
    parameter int MDU_TIMEOUT = 64
`ifdef HAZARD_STATS_EN
    , parameter int CNT_W = 16
`endif
) (
    input logic clk,
    input logic reset,
    hazard_control_unit_if.slave bus
);

    localparam int              TW      = $clog2(MDU_TIMEOUT);
    localparam logic [TW-1:0]   TO_LAST = TW'(MDU_TIMEOUT - 1);

    hcu_state_e            state_q, state_d;
    logic                  err_q, err_d;
    logic [REG_ADDR_W-1:0] rw;
    logic                  load_use;
    logic                  to_tc;
    logic [TW-1:0]         to_cnt_unused;
    logic                  mdu_release;
    logic                  mdu_timeout;
    logic                  pc_w, ifid_w, bub_w, fl_w, st_w;

    assign rw       = bus.rw_ID_EX;
    assign load_use = bus.mem_read_EX && (rw != REG_ZERO) &&
                      ((rw == bus.rs_ID) || (bus.uses_rt_ID && (rw == bus.rt_ID)));

    // to_tc is the last permitted wait cycle; done in that same cycle is not a timeout.
    assign mdu_release = bus.mdu_done || to_tc;
    assign mdu_timeout = (state_q == ST_MDU_WAIT) && !bus.mdu_done && to_tc;

    hazard_timeout_counter #(
        .W        (TW),
        .TC_VALUE (TO_LAST)
    ) u_mdu_timeout (
        .clk   (clk),
        .reset (reset),
        .clr_i (st_w),
        .en_i  (state_q == ST_MDU_WAIT),
        .cnt_o (to_cnt_unused),
        .tc_o  (to_tc)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_RUN;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        err_d   = err_q | mdu_timeout;
        case (state_q)
            ST_RUN: begin
                if (bus.branch_taken_EX) begin
                    state_d = ST_RUN;
                end else if (load_use) begin
                    state_d = ST_LOAD_STALL;
                end else if (bus.mdu_op_ID) begin
                    state_d = ST_MDU_WAIT;
                end
            end
            ST_LOAD_STALL: state_d = ST_RUN;
            ST_MDU_WAIT: begin
                if (mdu_release) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    // Reset forces the run values so fetch is not frozen while the core is held.
    always_comb begin
        pc_w   = 1'b1;
        ifid_w = 1'b1;
        bub_w  = 1'b0;
        fl_w   = 1'b0;
        st_w   = 1'b0;
        if (!reset) begin
            if (bus.branch_taken_EX) begin
                fl_w  = 1'b1;
                bub_w = 1'b1;
            end else begin
                case (state_q)
                    ST_RUN: begin
                        if (load_use) begin
                            pc_w   = 1'b0;
                            ifid_w = 1'b0;
                            bub_w  = 1'b1;
                        end else if (bus.mdu_op_ID) begin
                            st_w   = 1'b1;
                            pc_w   = 1'b0;
                            ifid_w = 1'b0;
                            bub_w  = 1'b1;
                        end
                    end
                    ST_MDU_WAIT: begin
                        if (!mdu_release) begin
                            pc_w   = 1'b0;
                            ifid_w = 1'b0;
                            bub_w  = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.pc_write     = pc_w;
    assign bus.if_id_write  = ifid_w;
    assign bus.id_ex_bubble = bub_w;
    assign bus.if_id_flush  = fl_w;
    assign bus.mdu_start    = st_w;
    assign bus.mdu_error    = err_q;

`ifdef HAZARD_STATS_EN
    logic stall_sat_unused;
    logic flush_sat_unused;

    hazard_timeout_counter #(.W(CNT_W)) u_stall_stats (
        .clk   (clk),
        .reset (reset),
        .clr_i (1'b0),
        .en_i  (!pc_w),
        .cnt_o (bus.stall_cycles),
        .tc_o  (stall_sat_unused)
    );

    hazard_timeout_counter #(.W(CNT_W)) u_flush_stats (
        .clk   (clk),
        .reset (reset),
        .clr_i (1'b0),
        .en_i  (fl_w),
        .cnt_o (bus.flush_count),
        .tc_o  (flush_sat_unused)
    );
`endif

endmodule
